sram_1rw_req_ctrl: RTL and testbench
====================================

# sram_1rw_req_ctrl

Request-side controller for the single-port `sram_96x4096_1rw` macro.
- Accepts valid/ready read and write requests and drives the macro's `ce_in`/`we_in`/`addr_in`/`wd_in`/`w_mask_in`.
- Captures `rd_out` one cycle after each read.
- Returns read data on a backpressurable response channel.
- Optionally zero-fills the whole array after reset.

## Interface
Parameters:
- `BITS`, 96, data/mask width.
- `WORD_DEPTH`, 4096, number of words.
- `ADDR_WIDTH`, 12, address width; `2**ADDR_WIDTH >= WORD_DEPTH`.
- `RSP_DEPTH`, 3, response FIFO entries; minimum 2; 3 sustains one read per cycle.

Ports:
- `clk` in 1: sole clock; one clock domain.
- `rst` in 1: reset, synchronous and active-high.
- `req_valid` in 1: request valid.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_WIDTH: word address.
- `req_wdata` in BITS: write data.
- `req_wmask` in BITS: bit i = 1 writes bit i.
- `rsp_valid` out 1: read data valid.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_rdata` out BITS: read data, in request order.
- `busy` out 1: initialization in progress.
- `sram_ce` out 1: connects to macro `ce_in`.
- `sram_we` out 1: connects to macro `we_in`.
- `sram_addr` out ADDR_WIDTH: connects to macro `addr_in`.
- `sram_wd` out BITS: connects to macro `wd_in`.
- `sram_wmask` out BITS: connects to macro `w_mask_in`.
- `sram_rd` in BITS: connects to macro `rd_out`.

## Operation
- States: `INIT` and `RUN`. Reset enters `INIT` if the configuration feature is compiled in, otherwise `RUN`.
- In `RUN`:
  - `req_ready = (fifo_count + rd_inflight) < RSP_DEPTH`.
  - `req_ready` depends only on registered state, never on `req_valid`, `req_we` or `rsp_ready`.
  - Writes are gated by the same credit rule, so writes stall while the read path is full.
- Accepted request (same cycle, combinational):
  - `sram_ce = 1`.
  - `sram_we = req_we`.
  - `sram_addr = req_addr`, `sram_wd = req_wdata`, `sram_wmask = req_wmask`.
- No accept: `sram_ce = 0`. Address, data and mask hold their last values; don't-care for the macro.
- Accepted read sets `rd_inflight` for one cycle. The next cycle `sram_rd` is pushed into the response FIFO.
- Writes produce no response.
- Response FIFO:
  - In-order queue.
  - `rsp_valid = fifo_count != 0`; `rsp_rdata` is the head entry.
  - Push and pop in the same cycle leave the count unchanged.
  - The credit rule guarantees a push never hits a full FIFO; the bench asserts this.
- Read-after-write to the same address in consecutive cycles returns the new data (macro write completes before the next access).
- Out-of-range addresses (`>= WORD_DEPTH`) pass through unchecked.

## Timing
- Reset values, while `rst` is high and the cycle after:
  - `req_ready = 0`, `rsp_valid = 0`, `sram_ce = 0`.
  - `busy = 1` if init is compiled in, else 0.
  - FIFO empty, `rd_inflight = 0`.
- Read latency:
  - Accept in cycle N.
  - Macro data at N+1.
  - `rsp_valid` at N+2 at the earliest.
- Throughput: one access per cycle with `RSP_DEPTH = 3` and `rsp_ready` held high.
- Reset mid-operation: the in-flight read is discarded, the FIFO is cleared, and queued responses are lost.

## Configuration
- Macro: `SRAM_CTRL_INIT_EN`.
- Defined:
  - After reset, `INIT` writes zero with an all-ones mask to addresses 0 through `WORD_DEPTH-1`, one per cycle, using an `ADDR_WIDTH`-bit counter.
  - During `INIT`: `busy = 1` and `req_ready = 0`.
  - Move to `RUN` after the cycle that writes `WORD_DEPTH-1`; `busy` falls the same cycle `RUN` begins.
  - Total `WORD_DEPTH` write cycles.
  - `rst` during `INIT` restarts at address 0.
- Undefined: no counter, `busy` tied 0, reset goes straight to `RUN`.

## Structure
- Package `sram_ctrl_pkg`: state enum (`INIT`, `RUN`) and default width/depth constants.
- Sub-module `sram_ctrl_rsp_fifo`: parameterized BITS × RSP_DEPTH synchronous FIFO with count output and the same reset.
- The top level holds the state machine, init counter, credit logic and `rd_inflight`.

## Test plan
- Reset, then all-ones write to address 5, then read 5 → `rsp_rdata = all-ones` at accept+2. With init compiled in, read 6 → 0 and `busy` is high for exactly 4096 cycles.
- Write 0xA5 pattern with mask 0x0F to address 10 (previously 0), then read 10 → 0x05 in the low byte, upper bits unchanged.
- 16 back-to-back reads of addresses 0–15 with `rsp_ready = 1` → `req_ready` stays high and responses arrive in order, one per cycle.
- `rsp_ready = 0` while issuing reads → after 3 accepts `req_ready = 0`; raise `rsp_ready` → 3 responses in order, then `req_ready` returns.
- Write address 7 = X in cycle N and read 7 in cycle N+1 → response X.
- Assert `rst` with 2 responses queued and 1 read in flight → `rsp_valid = 0` the next cycle; no stale response appears afterwards.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the sram_96x4096_1rw request controller.
package sram_ctrl_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    localparam int DEF_BITS       = 96;
    localparam int DEF_WORD_DEPTH = 4096;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_RSP_DEPTH  = 3;

endpackage

// File: rtl/sram_ctrl_rsp_fifo.sv
// In-order response queue, BITS wide x DEPTH entries, head visible combinationally.
// Latency: a push is visible at the head the next cycle.
// Backpressure: none internally; the producer must never push into a full queue.
module sram_ctrl_rsp_fifo #(
    parameter int BITS  = 96,
    parameter int DEPTH = 3,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [BITS-1:0] push_dat,
    input  logic            pop,
    output logic [BITS-1:0] head_dat,
    output logic [CW-1:0]   count
);

    logic [BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed once counted.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/sram_1rw_req_ctrl.sv
// Request controller for sram_96x4096_1rw; SRAM_CTRL_INIT_EN adds a zero-fill pass after reset.
// Latency: read accepted in cycle N returns on rsp_valid at N+2 at the earliest.
// Backpressure: req_ready drops once queued plus in-flight reads reach RSP_DEPTH.
module sram_1rw_req_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int BITS       = DEF_BITS,
    parameter int WORD_DEPTH = DEF_WORD_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [BITS-1:0]       req_wdata,
    input  logic [BITS-1:0]       req_wmask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [BITS-1:0]       rsp_rdata,
    output logic                  busy,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [BITS-1:0]       sram_wd,
    output logic [BITS-1:0]       sram_wmask,
    input  logic [BITS-1:0]       sram_rd
);

    localparam int CW = $clog2(RSP_DEPTH + 1);

    ctrl_state_e           state_q, state_d;
    logic                  arm_q;
    logic                  rd_inflight_q, rd_inflight_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [BITS-1:0]       wd_q, wmask_q;
    logic [CW-1:0]         fifo_count;
    logic                  credit_ok, accept, init_wr;

`ifdef SRAM_CTRL_INIT_EN
    localparam ctrl_state_e RST_STATE = INIT;
    logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
`else
    localparam ctrl_state_e RST_STATE = RUN;
`endif

    // arm_q keeps every request-side output quiet for one cycle after reset.
    assign credit_ok = (32'(fifo_count) + 32'(rd_inflight_q)) < RSP_DEPTH;
    assign req_ready = arm_q && (state_q == RUN) && credit_ok;
    assign accept    = req_valid && req_ready;
    assign init_wr   = arm_q && (state_q == INIT);

    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = addr_q;
        sram_wd    = wd_q;
        sram_wmask = wmask_q;
        state_d    = state_q;
        if (init_wr) begin
            sram_ce    = 1'b1;
            sram_we    = 1'b1;
            sram_wd    = '0;
            sram_wmask = '1;
`ifdef SRAM_CTRL_INIT_EN
            sram_addr  = init_cnt_q;
            if (init_cnt_q == ADDR_WIDTH'(WORD_DEPTH - 1)) begin
                state_d = RUN;
            end
`endif
        end else if (accept) begin
            sram_ce    = 1'b1;
            sram_we    = req_we;
            sram_addr  = req_addr;
            sram_wd    = req_wdata;
            sram_wmask = req_wmask;
        end
        rd_inflight_d = accept && !req_we;
    end

`ifdef SRAM_CTRL_INIT_EN
    always_comb begin
        init_cnt_d = init_cnt_q;
        if (init_wr) begin
            init_cnt_d = init_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt_q <= '0;
        end else begin
            init_cnt_q <= init_cnt_d;
        end
    end

    assign busy = (state_q == INIT);
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RST_STATE;
            arm_q         <= 1'b0;
            rd_inflight_q <= 1'b0;
            addr_q        <= '0;
            wd_q          <= '0;
            wmask_q       <= '0;
        end else begin
            state_q       <= state_d;
            arm_q         <= 1'b1;
            rd_inflight_q <= rd_inflight_d;
            addr_q        <= sram_addr;
            wd_q          <= sram_wd;
            wmask_q       <= sram_wmask;
        end
    end

    assign rsp_valid = (fifo_count != '0);

    sram_ctrl_rsp_fifo #(
        .BITS  (BITS),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_inflight_q),
        .push_dat (sram_rd),
        .pop      (rsp_valid && rsp_ready),
        .head_dat (rsp_rdata),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// Directed bench for sram_1rw_req_ctrl with a behavioural 1RW macro model.
module tb_sram_1rw_req_ctrl;

    localparam int BITS       = 96;
    localparam int WORD_DEPTH = 4096;
    localparam int ADDR_WIDTH = 12;
    localparam int RSP_DEPTH  = 3;

`ifdef SRAM_CTRL_INIT_EN
    localparam logic EXP_BUSY_RST = 1'b1;
    localparam logic EXP_RDY_POST = 1'b0;
`else
    localparam logic EXP_BUSY_RST = 1'b0;
    localparam logic EXP_RDY_POST = 1'b1;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_valid, req_ready, req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [BITS-1:0]       req_wdata, req_wmask;
    logic                  rsp_valid, rsp_ready;
    logic [BITS-1:0]       rsp_rdata;
    logic                  busy;
    logic                  sram_ce, sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [BITS-1:0]       sram_wd, sram_wmask, sram_rd;

    int total = 0;
    int bad   = 0;

    logic [BITS-1:0] mem [WORD_DEPTH];
    logic [BITS-1:0] pat [16];

    always #5 clk = ~clk;

    sram_1rw_req_ctrl #(
        .BITS(BITS), .WORD_DEPTH(WORD_DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy),
        .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wd(sram_wd), .sram_wmask(sram_wmask), .sram_rd(sram_rd)
    );

    // Macro model: masked write, registered read data.
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_we)
                mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wd & sram_wmask);
            else
                sram_rd <= mem[sram_addr];
        end
    end

    always @(posedge clk) begin
        if (!rst && dut.rd_inflight_q) begin
            total++;
            if (int'(dut.fifo_count) >= RSP_DEPTH && !(rsp_valid && rsp_ready)) begin
                bad++;
                $display("FAIL fifo_overflow: push with count=%0d, required below %0d",
                         dut.fifo_count, RSP_DEPTH);
            end
        end
    end

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
    endtask

    task automatic drive_req(input logic we, input int addr, input logic [BITS-1:0] wd,
                             input logic [BITS-1:0] wm);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = ADDR_WIDTH'(addr);
        req_wdata = wd;
        req_wmask = wm;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
`ifdef SRAM_CTRL_INIT_EN
        for (int i = 0; i < WORD_DEPTH + 100 && busy; i++) @(negedge clk);
`endif
        @(negedge clk);
    endtask

    task automatic test_reset();
        rsp_ready = 1'b1;
        drive_req(1'b0, 3, '0, '0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total += 4;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        if (sram_ce !== 1'b0) begin bad++; $display("FAIL rst_ce: got %b want 0", sram_ce); end
        if (busy !== EXP_BUSY_RST) begin bad++; $display("FAIL rst_busy: got %b want %b", busy, EXP_BUSY_RST); end
        rst = 1'b0;
        #1;
        total += 2;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL post_rst_ready: got %b want 0", req_ready); end
        if (sram_ce !== 1'b0) begin bad++; $display("FAIL post_rst_ce: got %b want 0", sram_ce); end
        idle_inputs();
        @(negedge clk);
        total++;
        if (req_ready !== EXP_RDY_POST) begin bad++; $display("FAIL ready_after_rst: got %b want %b", req_ready, EXP_RDY_POST); end
`ifdef SRAM_CTRL_INIT_EN
        begin
            int wr_cycles = 0;
            for (int i = 0; i < WORD_DEPTH + 100 && busy; i++) begin
                if (sram_ce && sram_we) wr_cycles++;
                @(negedge clk);
            end
            total += 2;
            if (wr_cycles != WORD_DEPTH) begin bad++; $display("FAIL init_writes: got %0d want %0d", wr_cycles, WORD_DEPTH); end
            if (busy !== 1'b0) begin bad++; $display("FAIL init_busy_end: got %b want 0", busy); end
        end
`endif
    endtask

    task automatic test_write_read();
        drive_req(1'b1, 5, '1, '1);
        #1;
        total += 4;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL wr_ready: got %b want 1", req_ready); end
        if (sram_ce !== 1'b1) begin bad++; $display("FAIL wr_ce: got %b want 1", sram_ce); end
        if (sram_we !== 1'b1) begin bad++; $display("FAIL wr_we: got %b want 1", sram_we); end
        if (sram_addr !== 12'd5) begin bad++; $display("FAIL wr_addr: got %0d want 5", sram_addr); end
        @(negedge clk);
        drive_req(1'b0, 5, '0, '0);
        @(negedge clk);
        idle_inputs();
        #1;
        total += 2;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_early: got %b want 0", rsp_valid); end
        if (sram_ce !== 1'b0) begin bad++; $display("FAIL idle_ce: got %b want 0", sram_ce); end
        @(negedge clk);
        total += 2;
        if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rd_valid: got %b want 1", rsp_valid); end
        if (rsp_rdata !== {BITS{1'b1}}) begin bad++; $display("FAIL rd_data: got %h want all ones", rsp_rdata); end
`ifdef SRAM_CTRL_INIT_EN
        drive_req(1'b0, 6, '0, '0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== '0) begin
            bad++; $display("FAIL init_zero: got v=%b %h want v=1 0", rsp_valid, rsp_rdata);
        end
`endif
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_drain: got %b want 0", rsp_valid); end
    endtask

    task automatic test_mask();
        logic [BITS-1:0] wd;
        wd = {12{8'hA5}};
        drive_req(1'b1, 10, wd, 96'h0F);
        @(negedge clk);
        drive_req(1'b0, 10, '0, '0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 96'h05) begin
            bad++; $display("FAIL mask_write: got v=%b %h want v=1 %h", rsp_valid, rsp_rdata, 96'h05);
        end
        @(negedge clk);
    endtask

    task automatic test_raw();
        logic [BITS-1:0] x;
        x = 96'h1234_5678_9ABC_DEF0_0F1E_2D3C;
        drive_req(1'b1, 7, x, '1);
        @(negedge clk);
        drive_req(1'b0, 7, '0, '0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== x) begin
            bad++; $display("FAIL raw: got v=%b %h want v=1 %h", rsp_valid, rsp_rdata, x);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            pat[i] = {32'hC0DE0000 + 32'(i), 32'(i) * 32'd7, ~32'(i)};
            drive_req(1'b1, i, pat[i], '1);
            @(negedge clk);
        end
        for (int j = 0; j < 18; j++) begin
            if (j < 16) begin
                total++;
                if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", j, req_ready); end
                drive_req(1'b0, j, '0, '0);
            end else begin
                idle_inputs();
            end
            if (j >= 2) begin
                total++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== pat[j-2]) begin
                    bad++; $display("FAIL b2b_rsp[%0d]: got v=%b %h want v=1 %h", j - 2, rsp_valid, rsp_rdata, pat[j-2]);
                end
            end
            @(negedge clk);
        end
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: got %b want 0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            total++;
            if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 1", j, req_ready); end
            drive_req(1'b0, j, '0, '0);
            @(negedge clk);
        end
        drive_req(1'b0, 3, '0, '0);
        total++;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_full: got %b want 0", req_ready); end
        @(negedge clk);
        idle_inputs();
        total += 2;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_hold: got %b want 0", req_ready); end
        if (rsp_valid !== 1'b1 || rsp_rdata !== pat[0]) begin
            bad++; $display("FAIL bp_rsp0: got v=%b %h want v=1 %h", rsp_valid, rsp_rdata, pat[0]);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        total += 2;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_resume: got %b want 1", req_ready); end
        if (rsp_valid !== 1'b1 || rsp_rdata !== pat[1]) begin
            bad++; $display("FAIL bp_rsp1: got v=%b %h want v=1 %h", rsp_valid, rsp_rdata, pat[1]);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== pat[2]) begin
            bad++; $display("FAIL bp_rsp2: got v=%b %h want v=1 %h", rsp_valid, rsp_rdata, pat[2]);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive_req(1'b0, 4 + j, '0, '0);
            @(negedge clk);
        end
        idle_inputs();
        total++;
        if (rsp_valid !== 1'b1) begin bad++; $display("FAIL mid_queued: got %b want 1", rsp_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid: got %b want 0", rsp_valid); end
        rsp_ready = 1'b1;
`ifdef SRAM_CTRL_INIT_EN
        for (int i = 0; i < WORD_DEPTH + 100 && busy; i++) begin
            if (rsp_valid !== 1'b0) begin total++; bad++; $display("FAIL mid_stale_init: got %b want 0", rsp_valid); end
            @(negedge clk);
        end
`endif
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_stale[%0d]: got %b want 0", k, rsp_valid); end
        end
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_ready_back: got %b want 1", req_ready); end
    endtask

    initial begin
        for (int i = 0; i < WORD_DEPTH; i++) mem[i] = '0;
        sram_rd   = '0;
        rst       = 1'b1;
        rsp_ready = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        do_reset();
        test_write_read();
        test_mask();
        test_raw();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
